// File: rtl/comb_cb.sv
// rtl/comb_cb.sv - multi-channel comb stage y = x[n] - x[n-DELAY] over a circular delay buffer
// Channels arrive interleaved; one RAM-mappable buffer holds DELAY samples per channel.
module comb_cb #(
    parameter  int I_BW       = 8,
    parameter  int O_BW       = 9,
    parameter  int DELAY      = 250,
    parameter  int NUM_CH     = 1,
    parameter  int SKIP_PRIME = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            en_i,
    input  logic [I_BW-1:0] data_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [O_BW-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [CH_W-1:0] ch_o,
    output logic            primed_o
);

    localparam int DEPTH = DELAY * NUM_CH;
    localparam int WP_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [I_BW-1:0] r_mem [DEPTH];
    logic [WP_W-1:0] r_wp;
    logic [CH_W-1:0] r_cc;
    logic            r_wrapped;
    logic            r_valid;
    logic [O_BW-1:0] r_data;
    logic [CH_W-1:0] r_ch;

    logic                   w_accept;
    logic                   w_wp_last;
    logic                   w_cc_last;
    logic [I_BW-1:0]        w_old;
    logic signed [I_BW:0]   w_new_sx;
    logic signed [I_BW:0]   w_old_sx;
    logic signed [I_BW:0]   w_diff;
    logic signed [O_BW-1:0] w_diff_ext;

    assign ready_o   = en_i & (~r_valid | ready_i);
    assign w_accept  = valid_i & ready_o;
    assign w_wp_last = (r_wp == WP_W'(DEPTH - 1));
    assign w_cc_last = (r_cc == CH_W'(NUM_CH - 1));

    // Until the first wrap the buffer content is meaningless, so behave like a zero-filled line.
    assign w_old      = r_wrapped ? r_mem[r_wp] : '0;
    assign w_new_sx   = {data_i[I_BW-1], data_i};
    assign w_old_sx   = {w_old[I_BW-1], w_old};
    assign w_diff     = w_new_sx - w_old_sx;
    assign w_diff_ext = O_BW'(w_diff);

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mem[r_wp] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wp      <= '0;
            r_cc      <= '0;
            r_wrapped <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ch      <= '0;
        end else if (!en_i) begin
            r_wp      <= '0;
            r_cc      <= '0;
            r_wrapped <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ch      <= '0;
        end else if (w_accept) begin
            r_data  <= w_diff_ext;
            r_ch    <= r_cc;
            r_valid <= !((SKIP_PRIME != 0) && !r_wrapped);
            r_wp    <= w_wp_last ? '0 : r_wp + WP_W'(1);
            r_cc    <= w_cc_last ? '0 : r_cc + CH_W'(1);
            if (w_wp_last) begin
                r_wrapped <= 1'b1;
            end
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign data_o   = r_data;
    assign valid_o  = r_valid;
    assign ch_o     = r_ch;
    assign primed_o = r_wrapped;

endmodule
